// File: rtl/cache_rd_arbiter.sv
// Shares one AXI AR/R channel between icache refill, dcache refill and dcache uncached loads (CACHE_ARB_RR_EN selects round-robin over dcache priority).
// Request to rend: 10 cycles for a refill, 3 for an uncached load with a zero-wait slave; one transaction outstanding, requests wait in IDLE.
module cache_rd_arbiter #(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       ic_rreq_i,
  input  logic [31:0]                ic_raddr_i,
  output logic                       ic_rend_o,
  output logic [LINE_WORDS*32-1:0]   ic_line_o,

  input  logic                       dc_rreq_i,
  input  logic                       dc_uc_i,
  input  logic [31:0]                dc_raddr_i,
  input  logic [1:0]                 dc_load_size_i,
  output logic                       dc_rend_o,
  output logic [LINE_WORDS*32-1:0]   dc_line_o,

  output logic [3:0]                 arid_o,
  output logic [31:0]                araddr_o,
  output logic [7:0]                 arlen_o,
  output logic [2:0]                 arsize_o,
  output logic [1:0]                 arburst_o,
  output logic                       arvalid_o,
  input  logic                       arready_i,

  input  logic [31:0]                rdata_i,
  input  logic [1:0]                 rresp_i,
  input  logic                       rlast_i,
  input  logic                       rvalid_i,
  output logic                       rready_o
);

  localparam int unsigned CW   = $clog2(LINE_WORDS);
  localparam int unsigned OFFS = $clog2(LINE_WORDS * 4);
  localparam logic [7:0]  REFILL_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_cnt;
  logic [LINE_WORDS-1:0][31:0]   r_buf;
  logic                          r_gnt_dc;
  logic                          r_ic_rend;
  logic                          r_dc_rend;
  logic [31:0]                   r_araddr;
  logic [7:0]                    r_arlen;
  logic [2:0]                    r_arsize;
  logic [1:0]                    r_arburst;
  logic                          r_arvalid;
  logic                          r_rready;

  logic                          w_any_req;
  logic                          w_pick_dc;
  logic                          w_uc;
  logic                          w_beat;
  logic [31:0]                   w_addr;
  logic [31:0]                   w_line_addr;
  logic                          w_unused;

  assign w_any_req   = ic_rreq_i | dc_rreq_i;
  assign w_uc        = w_pick_dc & dc_uc_i;
  assign w_addr      = w_pick_dc ? dc_raddr_i : ic_raddr_i;
  assign w_line_addr = {w_addr[31:OFFS], {OFFS{1'b0}}};
  assign w_beat      = rvalid_i & r_rready;
  // Response status is deliberately not acted on; the line is delivered regardless.
  assign w_unused    = ^{rresp_i, ic_raddr_i[OFFS-1:0]};

`ifdef CACHE_ARB_RR_EN
  logic r_last_ic;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_ic <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_ic <= ~w_pick_dc;
    end
  end

  assign w_pick_dc = dc_rreq_i & (~ic_rreq_i | r_last_ic);
`else
  assign w_pick_dc = dc_rreq_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_gnt_dc  <= 1'b0;
      r_ic_rend <= 1'b0;
      r_dc_rend <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      r_ic_rend <= 1'b0;
      r_dc_rend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_dc  <= w_pick_dc;
            r_araddr  <= w_uc ? w_addr : w_line_addr;
            r_arlen   <= w_uc ? 8'd0 : REFILL_LEN;
            r_arsize  <= w_uc ? {1'b0, dc_load_size_i} : 3'd2;
            r_arburst <= 2'b01;
            r_cnt     <= '0;
            r_arvalid <= 1'b1;
            r_state   <= S_AR;
          end
        end
        S_AR: begin
          if (arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (w_beat) begin
            // Counter wraps, so an overlong burst overwrites from word 0.
            r_buf[r_cnt] <= rdata_i;
            r_cnt        <= r_cnt + 1'b1;
            if (rlast_i) begin
              r_rready  <= 1'b0;
              r_ic_rend <= ~r_gnt_dc;
              r_dc_rend <= r_gnt_dc;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign arid_o    = AXI_ID;
  assign araddr_o  = r_araddr;
  assign arlen_o   = r_arlen;
  assign arsize_o  = r_arsize;
  assign arburst_o = r_arburst;
  assign arvalid_o = r_arvalid;
  assign rready_o  = r_rready;
  assign ic_rend_o = r_ic_rend;
  assign dc_rend_o = r_dc_rend;
  assign ic_line_o = r_buf;
  assign dc_line_o = r_buf;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: directed and random requests against a line-buffer model,
// AR and rend checked by a monitor that pops expectations queued by the driver.
module tb_cache_rd_arbiter;

  localparam logic [3:0] AXI_ID = 4'h5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_rreq_i, dc_rreq_i, dc_uc_i;
  logic [31:0]  ic_raddr_i, dc_raddr_i;
  logic [1:0]   dc_load_size_i;
  logic         ic_rend_o, dc_rend_o;
  logic [255:0] ic_line_o, dc_line_o;
  logic [3:0]   arid_o;
  logic [31:0]  araddr_o;
  logic [7:0]   arlen_o;
  logic [2:0]   arsize_o;
  logic [1:0]   arburst_o;
  logic         arvalid_o, arready_i;
  logic [31:0]  rdata_i;
  logic [1:0]   rresp_i;
  logic         rlast_i, rvalid_i, rready_o;

  cache_rd_arbiter #(.LINE_WORDS(8), .AXI_ID(AXI_ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_rreq_i(ic_rreq_i), .ic_raddr_i(ic_raddr_i), .ic_rend_o(ic_rend_o), .ic_line_o(ic_line_o),
    .dc_rreq_i(dc_rreq_i), .dc_uc_i(dc_uc_i), .dc_raddr_i(dc_raddr_i),
    .dc_load_size_i(dc_load_size_i), .dc_rend_o(dc_rend_o), .dc_line_o(dc_line_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; logic [2:0] size; } ar_t;
  typedef struct packed { logic is_dc; logic uc; logic [255:0] line; } rend_t;

  ar_t         exp_ar[$];
  rend_t       exp_rend[$];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic [31:0] mbuf [8];
  bit          m_last_ic;
  bit          ic_pend, dc_pend;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mbuf[i] = '0;
    m_last_ic = 1'b1;
  endtask

  // Monitor: compares every AR issue and every rend pulse against the queued expectations.
  logic        prev_arv = 1'b0;
  logic [42:0] held;
  ar_t         mon_e;
  rend_t       mon_r;
  always @(negedge clk) begin
    if (rst_n) begin
      if (arvalid_o && !prev_arv) begin
        if (exp_ar.size() == 0) fail("ar_unexpected");
        else begin
          mon_e = exp_ar.pop_front();
          chk("araddr", araddr_o, mon_e.addr);
          chk("arlen", arlen_o, mon_e.len);
          chk("arsize", arsize_o, mon_e.size);
          chk("arburst", arburst_o, 2'b01);
          chk("arid", arid_o, AXI_ID);
        end
        held = {araddr_o, arlen_o, arsize_o};
      end else if (arvalid_o) begin
        chk("ar_stable", {araddr_o, arlen_o, arsize_o}, held);
      end
      if (ic_rend_o && dc_rend_o) fail("rend_both");
      else if (ic_rend_o || dc_rend_o) begin
        if (exp_rend.size() == 0) fail("rend_unexpected");
        else begin
          mon_r = exp_rend.pop_front();
          chk("rend_owner", dc_rend_o, mon_r.is_dc);
          if (mon_r.uc) chk("uc_word", dc_line_o[31:0], mon_r.line[31:0]);
          else chk("line", mon_r.is_dc ? dc_line_o : ic_line_o, mon_r.line);
        end
      end
    end
    prev_arv = arvalid_o;
  end

  // One transaction: raise requests, serve whichever one the model says wins, wait for its rend.
  task automatic txn(input bit r_ic, input bit r_dc, input logic [31:0] a_ic, input logic [31:0] a_dc,
                     input bit uc, input logic [1:0] sz, input int arw, input int gap, input int nb_ref,
                     input logic [31:0] dbase, input bit rnd, input int exp_lat, input int rst_beat);
    bit          win_dc, is_uc, took;
    int          t0, k, gl, tmo, nb;
    logic [31:0] dat [16];
    ar_t         e;
    rend_t       r;
    @(negedge clk);
    if (r_ic && !ic_pend) begin
      ic_rreq_i = 1'b1; ic_raddr_i = a_ic; ic_pend = 1'b1;
    end
    if (r_dc && !dc_pend) begin
      dc_rreq_i = 1'b1; dc_raddr_i = a_dc; dc_uc_i = uc; dc_load_size_i = sz; dc_pend = 1'b1;
    end
    if (!ic_pend && !dc_pend) return;
`ifdef CACHE_ARB_RR_EN
    win_dc = dc_pend && (!ic_pend || m_last_ic);
`else
    win_dc = dc_pend;
`endif
    m_last_ic = !win_dc;
    is_uc = win_dc && dc_uc_i;
    nb = is_uc ? 1 : nb_ref;
    e.addr = is_uc ? dc_raddr_i : ((win_dc ? dc_raddr_i : ic_raddr_i) & 32'hFFFF_FFE0);
    e.len  = is_uc ? 8'd0 : 8'd7;
    e.size = is_uc ? {1'b0, dc_load_size_i} : 3'd2;
    exp_ar.push_back(e);
    for (int i = 0; i < nb; i++) begin
      dat[i] = rnd ? $urandom : dbase + 32'(i);
      mbuf[i % 8] = dat[i];
    end
    r.is_dc = win_dc;
    r.uc    = is_uc;
    for (int i = 0; i < 8; i++) r.line[32*i +: 32] = mbuf[i];
    exp_rend.push_back(r);
    t0 = cyc;

    tmo = 0;
    do begin @(negedge clk); tmo++; end while (!arvalid_o && tmo < 20);
    if (!arvalid_o) begin fail("ar_timeout"); return; end
    repeat (arw) @(negedge clk);
    arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0;

    k = 0; gl = 0; tmo = 0;
    while (k < nb && tmo < 200) begin
      if (gl > 0) begin
        rvalid_i = 1'b0; rlast_i = 1'b0; gl--;
      end else begin
        rvalid_i = 1'b1; rdata_i = dat[k]; rlast_i = (k == nb - 1);
        rresp_i = 2'($urandom_range(0, 3));
      end
      if (k == rst_beat) begin
        rst_n = 1'b0;
        ic_rreq_i = 1'b0; dc_rreq_i = 1'b0; ic_pend = 1'b0; dc_pend = 1'b0;
        void'(exp_rend.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("rst_rready", rready_o, 1'b0);
        chk("rst_arvalid", arvalid_o, 1'b0);
        chk("rst_rend", {ic_rend_o, dc_rend_o}, 2'b00);
        chk("rst_line", ic_line_o, 256'h0);
        rlast_i = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("rready_after_rst", rready_o, 1'b0);
        end
        rvalid_i = 1'b0; rlast_i = 1'b0;
        return;
      end
      took = rvalid_i && rready_o;
      @(negedge clk);
      tmo++;
      if (took) begin k++; gl = gap; end
    end
    rvalid_i = 1'b0; rlast_i = 1'b0;
    if (k < nb) fail("beat_timeout");

    tmo = 0;
    while (!(win_dc ? dc_rend_o : ic_rend_o) && tmo < 20) begin @(negedge clk); tmo++; end
    if (!(win_dc ? dc_rend_o : ic_rend_o)) fail("rend_timeout");
    else if (exp_lat > 0) chk("latency", 32'(cyc - t0), 32'(exp_lat));
    if (win_dc) begin dc_rreq_i = 1'b0; dc_pend = 1'b0; end
    else begin ic_rreq_i = 1'b0; ic_pend = 1'b0; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mode;
    bit uc;
    rst_n = 1'b0;
    ic_rreq_i = 0; dc_rreq_i = 0; dc_uc_i = 0; ic_raddr_i = 0; dc_raddr_i = 0; dc_load_size_i = 0;
    arready_i = 0; rdata_i = 0; rresp_i = 0; rlast_i = 0; rvalid_i = 0;
    ic_pend = 0; dc_pend = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_arvalid", arvalid_o, 1'b0);
    chk("reset_rready", rready_o, 1'b0);
    chk("reset_rend", {ic_rend_o, dc_rend_o}, 2'b00);
    chk("reset_ar_fields", {araddr_o, arlen_o, arsize_o, arburst_o}, 45'h0);
    chk("reset_arid", arid_o, AXI_ID);
    chk("reset_line", dc_line_o, 256'h0);
    rst_n = 1'b1;

    txn(1, 0, 32'h1FC0_0124, 0, 0, 0, 0, 0, 8, 32'h100, 0, 10, -1);
    txn(0, 1, 0, 32'hBFAF_8002, 1, 2'd1, 0, 0, 8, 32'h0000_BEEF, 0, 3, -1);
    txn(1, 1, 32'h0000_1040, 32'h0000_2080, 0, 0, 0, 0, 8, 32'h200, 0, 0, -1);
    txn(0, 1, 0, 32'h0000_30C0, 0, 0, 0, 0, 8, 32'h300, 0, 0, -1);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 8, 32'h400, 0, 0, -1);
    txn(1, 0, 32'h8000_0000, 0, 0, 0, 5, 2, 8, 32'h500, 0, 0, -1);
    txn(0, 1, 0, 32'h0000_4444, 0, 0, 0, 0, 4, 32'h600, 0, 0, -1);
    txn(1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 8, 32'h700, 0, 0, 2);
    txn(1, 0, 32'h0000_0A00, 0, 0, 0, 0, 0, 8, 32'h800, 0, 10, -1);
    txn(1, 1, 32'h0000_0B00, 32'h0000_0C00, 0, 0, 0, 0, 8, 32'h900, 0, 0, -1);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 8, 32'hA00, 0, 0, -1);
    txn(0, 1, 0, 32'h0000_0D00, 0, 0, 0, 1, 10, 32'hB00, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      uc = ($urandom_range(0, 3) == 0);
      txn(mode != 1, mode != 0, $urandom, $urandom, uc, 2'($urandom_range(0, 2)),
          $urandom_range(0, 3), $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 8, 0, 1, 0, -1);
    end
    txn(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0, -1);
    repeat (3) @(negedge clk);
    chk("ar_leftover", 32'(exp_ar.size()), 32'd0);
    chk("rend_leftover", 32'(exp_rend.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
